// File: rtl/core_pkg.sv
// Shared core types: data width, ALU/MulDiv opcodes and the MulDiv FSM state encoding.
package core_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] data_t;
  typedef logic            bool_t;

  typedef enum logic [3:0] {
    AluAdd, AluSub, AluAnd, AluOr, AluXor, AluSll, AluSrl, AluSra, AluSlt, AluSltu
  } alu_op_e;

  typedef enum logic [2:0] {
    MdMul    = 3'd0,
    MdMulh   = 3'd1,
    MdMulhsu = 3'd2,
    MdMulhu  = 3'd3,
    MdDiv    = 3'd4,
    MdDivu   = 3'd5,
    MdRem    = 3'd6,
    MdRemu   = 3'd7
  } muldiv_op_e;

  typedef logic [1:0] muldiv_state_t;
  localparam muldiv_state_t IDLE = 2'd0;
  localparam muldiv_state_t CALC = 2'd1;
  localparam muldiv_state_t DONE = 2'd2;

  function automatic logic op_signed_a(input logic [2:0] op);
    return op inside {MdMul, MdMulh, MdMulhsu, MdDiv, MdRem};
  endfunction

  function automatic logic op_signed_b(input logic [2:0] op);
    return op inside {MdMul, MdMulh, MdDiv, MdRem};
  endfunction

endpackage

// File: rtl/muldiv_fixup.sv
// Combinational sign handling for muldiv_unit: operand magnitudes and a negate flag on the
// way in, sign correction and result selection on the way out.
module muldiv_fixup #(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]        op,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic [XLEN-1:0]   mag_a,
  output logic [XLEN-1:0]   mag_b,
  output logic              neg,
  input  logic [2:0]        res_op,
  input  logic              res_neg,
  input  logic [2*XLEN-1:0] res_raw,
  output logic [XLEN-1:0]   res
);
  import core_pkg::*;

  logic              sa;
  logic              sb;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   div_val;

  always_comb begin
    sa    = op_signed_a(op) & a[XLEN-1];
    sb    = op_signed_b(op) & b[XLEN-1];
    mag_a = sa ? -a : a;
    mag_b = sb ? -b : b;
    // Remainder takes the dividend's sign; everything else the xor of both signs.
    neg   = (op inside {MdRem, MdRemu}) ? sa : (sa ^ sb);
  end

  always_comb begin
    prod    = res_neg ? -res_raw : res_raw;
    div_val = res_op[1] ? res_raw[2*XLEN-1:XLEN] : res_raw[XLEN-1:0];
    if (res_op[2]) begin
      res = res_neg ? -div_val : div_val;
    end else if (res_op == MdMul) begin
      res = prod[XLEN-1:0];
    end else begin
      res = prod[2*XLEN-1:XLEN];
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M unit: shift-add multiply and restoring divide, one op at a time.
// Optional MULDIV_FAST_MUL_EN: single-cycle multiplies via one 33x33 signed multiplier.
module muldiv_unit #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ITER_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            busy
);
  import core_pkg::*;

  muldiv_state_t     state_q, state_d;
  logic [ITER_W-1:0] counter_q, counter_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   resp_data_q, resp_data_d;

  logic [XLEN-1:0]   mag_a, mag_b;
  logic              neg;
  logic [2:0]        fix_op;
  logic              fix_neg;
  logic [2*XLEN-1:0] fix_raw;
  logic [XLEN-1:0]   fix_res;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_s;
  logic [XLEN:0]     rem_diff;
  logic [2*XLEN-1:0] acc_next;
  logic              special;
  logic              ovf;
  logic [XLEN-1:0]   spec_res;

  // One iteration of either algorithm; acc holds {hi, lo} = {partial/remainder, mplier/quotient}.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    rem_s    = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    rem_diff = rem_s - {1'b0, mcand_q};
    if (!op_q[2]) begin
      acc_next = {mul_sum, acc_q[XLEN-1:1]};
    end else if (rem_s >= {1'b0, mcand_q}) begin
      acc_next = {rem_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      acc_next = {rem_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end
  end

  always_comb begin
    ovf      = (req_op inside {MdDiv, MdRem}) && (req_a == {1'b1, {(XLEN-1){1'b0}}}) && (&req_b);
    special  = req_op[2] && ((req_b == '0) || ovf);
    if (req_b == '0) spec_res = req_op[1] ? req_a : '1;
    else             spec_res = req_op[1] ? '0 : req_a;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0]     fast_a, fast_b;
  logic signed [2*XLEN+1:0] fast_prod;

  always_comb begin
    fast_a    = {op_signed_a(req_op) & req_a[XLEN-1], req_a};
    fast_b    = {op_signed_b(req_op) & req_b[XLEN-1], req_b};
    fast_prod = fast_a * fast_b;
    fix_op    = (state_q == IDLE) ? req_op : op_q;
    fix_neg   = (state_q == IDLE) ? 1'b0 : neg_q;
    fix_raw   = (state_q == IDLE) ? fast_prod[2*XLEN-1:0] : acc_next;
  end
`else
  always_comb begin
    fix_op  = op_q;
    fix_neg = neg_q;
    fix_raw = acc_next;
  end
`endif

  muldiv_fixup #(
    .XLEN (XLEN)
  ) u_fixup (
    .op      (req_op),
    .a       (req_a),
    .b       (req_b),
    .mag_a   (mag_a),
    .mag_b   (mag_b),
    .neg     (neg),
    .res_op  (fix_op),
    .res_neg (fix_neg),
    .res_raw (fix_raw),
    .res     (fix_res)
  );

  always_comb begin
    state_d     = state_q;
    counter_d   = counter_q;
    op_d        = op_q;
    neg_d       = neg_q;
    mcand_d     = mcand_q;
    acc_d       = acc_q;
    resp_data_d = resp_data_q;
    if (flush) begin
      state_d   = IDLE;
      counter_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            op_d      = req_op;
            neg_d     = neg;
            mcand_d   = mag_b;
            acc_d     = {{XLEN{1'b0}}, mag_a};
            counter_d = '0;
            if (special) begin
              resp_data_d = spec_res;
              state_d     = DONE;
`ifdef MULDIV_FAST_MUL_EN
            end else if (!req_op[2]) begin
              resp_data_d = fix_res;
              state_d     = DONE;
`endif
            end else begin
              state_d = CALC;
            end
          end
        end
        CALC: begin
          acc_d = acc_next;
          if (counter_q == ITER_W'(XLEN-1)) begin
            resp_data_d = fix_res;
            counter_d   = '0;
            state_d     = DONE;
          end else begin
            counter_d = counter_q + 1'b1;
          end
        end
        DONE: begin
          if (resp_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      counter_q   <= '0;
      op_q        <= '0;
      neg_q       <= 1'b0;
      mcand_q     <= '0;
      acc_q       <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      counter_q   <= counter_d;
      op_q        <= op_d;
      neg_q       <= neg_d;
      mcand_q     <= mcand_d;
      acc_q       <= acc_d;
      resp_data_q <= resp_data_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign resp_data  = resp_data_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Multi-cycle RV32M execution unit, the sequential counterpart of the single-cycle integer ALU. Accepts requests from decode/issue over a valid/ready handshake and returns the result over a second valid/ready handshake to writeback. Multiply uses iterative shift-add; divide uses iterative restoring division. Processes one operation at a time, with no internal queue.

Parameters:
XLEN, 32, operand/result width; only 32 supported
ITER_W, 5, iteration counter width, $clog2(XLEN)

Ports:
clk  in  1  core clock
rst_n  in  1  reset, asynchronous assert, active-low
flush  in  1  pipeline flush; aborts the in-flight op
req_valid  in  1  request present
req_ready  out  1  unit can accept; high only in IDLE
req_op  in  3  MulDivOp: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7
req_a  in  XLEN  rs1 operand
req_b  in  XLEN  rs2 operand
resp_valid  out  1  result present; high only in DONE
resp_ready  in  1  writeback accepts result
resp_data  out  XLEN  result
busy  out  1  state != IDLE

Behaviour:
- Clocking: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_data=0, busy=0, counter=0.
- FSM states and transitions:
  - IDLE: on req_valid && req_ready, latch op, operands and operand signs. A special case goes to DONE; otherwise go to CALC with counter=0.
  - CALC: one iteration per cycle. At counter==31, apply the sign fix-up, register resp_data and go to DONE. Otherwise counter+1.
  - DONE: hold resp_valid and resp_data stable until resp_ready. On handshake, go to IDLE. No new request is accepted in the same cycle, so there is no back-to-back overlap.
- Latency:
  - Normal ops: resp_valid high 32 cycles after the accepting edge (1 load edge plus 32 iteration edges, the last of which registers the result).
  - Special cases: resp_valid high 1 cycle after the accepting edge.
- Signed handling: operands are converted to magnitude at load. MULH treats both operands as signed. MULHSU treats rs1 as signed and rs2 as unsigned. The result is negated at the end when signs differ.
- Multiply: 64-bit product accumulator. MUL returns the low 32 bits; MULH, MULHSU and MULHU return the high 32 bits.
- Divide:
  - Quotient sign is sign(a)^sign(b).
  - Remainder sign is sign(a).
- Special cases, all with 1-cycle latency and no CALC:
  - DIV or DIVU by 0: quotient = 0xFFFFFFFF.
  - REM or REMU by 0: remainder = a.
  - DIV of 0x80000000 by 0xFFFFFFFF: quotient = 0x80000000.
  - REM of 0x80000000 by 0xFFFFFFFF: remainder = 0.
- flush:
  - In any state, next state = IDLE and resp_valid drops.
  - The in-flight result is discarded and never presented.
  - flush has priority over req and resp handshakes in the same cycle, so a request offered in a flush cycle is not accepted.
- Reset mid-operation: immediate return to reset values; no response is ever produced for the aborted op.
- resp_data is held stable while resp_valid && !resp_ready.

Optional Feature:
MULDIV_FAST_MUL_EN
- Defined:
  - MUL, MULH, MULHSU and MULHU are computed with a single 33x33 signed multiply at load.
  - The FSM goes IDLE to DONE directly, with 1-cycle latency.
  - Divide is unchanged.
- Undefined: all multiplies use the 32-cycle iterative path. No multiplier is inferred.

Decomposition:
- Shared package (core_pkg), alongside Data, Bool and ALUOp:
  - MulDivOp enum
  - MulDivState enum (IDLE, CALC, DONE)
  - XLEN constant
- One natural sub-module: muldiv_fixup. It is purely combinational and performs the operand magnitude conversion and the result sign correction, shared by multiply and divide.
- The FSM and datapath registers stay in muldiv_unit.

Test Plan:
- MUL 7 x -3, resp_ready=1 -> resp_data=0xFFFFFFEB, resp_valid exactly 32 cycles after accept (1 cycle if MULDIV_FAST_MUL_EN).
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV -7 / 2 -> 0xFFFFFFFD. REM -7 / 2 -> 0xFFFFFFFF. DIVU 100 / 7 -> 14. REMU 100 / 7 -> 2.
- DIV 5 / 0 -> 0xFFFFFFFF, and REM 5 / 0 -> 5, both 1 cycle after accept. DIV 0x80000000 / -1 -> 0x80000000 and REM -> 0.
- Hold resp_ready=0 for 10 cycles in DONE -> resp_valid and resp_data stable, req_ready=0. Then pulse resp_ready -> IDLE the next cycle.
- Assert flush at CALC counter=10 with req_valid=1 in the same cycle -> IDLE, no resp_valid, request not taken. Deassert rst_n mid-CALC -> all outputs at reset values immediately.
